mem_copy_master: RTL

- Bus initiator for one 8-bit data-memory bank: drives Address/WriteData/MemWrite/MemRead and samples ReadData.
- Copies Length bytes from SrcAddr to DstAddr within the same bank using a Start/Done handshake.
- Sits between the control FSM and a single memory bank, for example to stage data into a bank before a compute pass.

---
 rtl/mem_copy_pkg.sv | 26 ++
 rtl/mem_copy_ctr.sv | 53 +++++
 rtl/mem_copy_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared types and constants for the mem_copy_master bank initiator.
//   state_t      : FSM encoding (IDLE, RD, WR, FIN)
//   *_W_DEF      : default bank address / data / length widths
//   RST_*        : values forced by the asynchronous active-low reset
// Optional feature macro used by the design: MEM_COPY_FILL_EN
// -----------------------------------------------------------------------------
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  // One extra bit so that a full 256-byte bank copy can be requested.
  localparam int LEN_W_DEF  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_BIT   = 1'b0;

endpackage

// File: rtl/mem_copy_ctr.sv
// -----------------------------------------------------------------------------
// mem_copy_ctr
// Loadable byte-index counter for mem_copy_master.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : clear the index and capture the transfer length
//   i_inc        : advance the index by one
//   i_len        : transfer length (only sampled with i_load, must be != 0)
//   o_idx_next   : index value that will be held after the coming edge
//   o_last       : terminal count, high while idx == length-1
// -----------------------------------------------------------------------------
module mem_copy_ctr
  import mem_copy_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_idx_next,
  output logic             o_last
);

  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_last_idx;

  // The top needs the post-edge index to register its Moore address output.
  always_comb begin
    o_idx_next = r_idx;
    if (i_load) begin
      o_idx_next = '0;
    end else if (i_inc) begin
      o_idx_next = r_idx + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_last_idx <= '0;
    end else begin
      r_idx <= o_idx_next;
      if (i_load) begin
        r_last_idx <= i_len - LEN_W'(1);
      end
    end
  end

  assign o_last = (r_idx == r_last_idx);

endmodule

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Bus initiator for one data-memory bank: copies Length bytes from SrcAddr to
// DstAddr (ascending, addresses wrap) with a Start/Done handshake.
// Handshake: Start is a one-cycle request that is only honoured while the
// block is IDLE (Busy low); Done pulses for one cycle when the transfer ends.
// Ports:
//   Clk, Rst                    : clock, asynchronous active-low reset
//   Start, SrcAddr, DstAddr,
//   Length                      : request and operands, captured on accept
//   Fill, FillValue             : fill request (only with MEM_COPY_FILL_EN)
//   Busy, Done                  : status
//   Address, WriteData,
//   MemWrite, MemRead, ReadData : bank interface (ReadData combinational)
//   o_dbg_state                 : current FSM state for debug/checkers
// Optional feature macro: MEM_COPY_FILL_EN (fill DstAddr.. with FillValue).
// -----------------------------------------------------------------------------
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
`ifdef MEM_COPY_FILL_EN
  input  logic              Fill,
  input  logic [DATA_W-1:0] FillValue,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData,
  output logic [1:0]        o_dbg_state
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic              w_ctr_load;
  logic              w_ctr_inc;
  logic              w_ctr_last;
  logic [LEN_W-1:0]  w_idx_n;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] w_src_n;
  logic [ADDR_W-1:0] w_dst_n;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              w_fill_in;
  logic              w_fill_cur;
  logic              w_fill_n;
  logic [DATA_W-1:0] w_fill_val;

`ifdef MEM_COPY_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_val;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fill     <= RST_BIT;
      r_fill_val <= '0;
    end else if (w_accept) begin
      r_fill     <= Fill;
      r_fill_val <= FillValue;
    end
  end

  assign w_fill_in  = Fill;
  assign w_fill_cur = r_fill;
  assign w_fill_val = w_accept ? FillValue : r_fill_val;
`else
  assign w_fill_in  = 1'b0;
  assign w_fill_cur = 1'b0;
  assign w_fill_val = '0;
`endif

  // Fill mode of the transfer that will be running after the coming edge.
  assign w_fill_n = w_accept ? w_fill_in : w_fill_cur;
  assign w_src_n  = w_accept ? SrcAddr : r_src;
  assign w_dst_n  = w_accept ? DstAddr : r_dst;

  mem_copy_ctr #(
    .LEN_W (LEN_W)
  ) u_ctr (
    .clk        (Clk),
    .rst_n      (Rst),
    .i_load     (w_ctr_load),
    .i_inc      (w_ctr_inc),
    .i_len      (Length),
    .o_idx_next (w_idx_n),
    .o_last     (w_ctr_last)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ctr_load   = 1'b0;
    w_ctr_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          if (Length == '0) begin
            w_next_state = FIN;
          end else begin
            w_ctr_load   = 1'b1;
            w_next_state = w_fill_in ? WR : RD;
          end
        end
      end
      RD: w_next_state = WR;
      WR: begin
        if (w_ctr_last) begin
          w_next_state = FIN;
        end else begin
          w_ctr_inc    = 1'b1;
          w_next_state = w_fill_cur ? WR : RD;
        end
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean Moore
  // output of the state it belongs to. Address/data only move in RD/WR.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RST_STATE;
      r_src       <= '0;
      r_dst       <= '0;
      r_busy      <= RST_BIT;
      r_done      <= RST_BIT;
      r_address   <= '0;
      r_data      <= '0;
      r_mem_write <= RST_BIT;
      r_mem_read  <= RST_BIT;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state != IDLE);
      r_done      <= (w_next_state == FIN);
      r_mem_read  <= (w_next_state == RD);
      r_mem_write <= (w_next_state == WR);
      if (w_accept) begin
        r_src <= SrcAddr;
        r_dst <= DstAddr;
      end
      case (w_next_state)
        RD: r_address <= w_src_n + w_idx_n[ADDR_W-1:0];
        WR: begin
          r_address <= w_dst_n + w_idx_n[ADDR_W-1:0];
          // Entering WR from RD latches the byte the bank is returning now.
          r_data    <= w_fill_n ? w_fill_val : ReadData;
        end
        default: ;
      endcase
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Address     = r_address;
  assign WriteData   = r_data;
  assign MemWrite    = r_mem_write;
  assign MemRead     = r_mem_read;
  assign o_dbg_state = r_state;

endmodule
